// File: rtl/dbuf_filt_sync.sv
// Multi-channel synchronising digital buffer: per-channel sync chain, optional
// inversion and consecutive-sample deglitch filter with registered edge pulses.

module dbuf_filt_lane #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CNT    = 4,
    parameter logic RST_BIT     = 1'b0,
    parameter logic INV_BIT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic byp,
    input  logic d,
    output logic o,
    output logic rise,
    output logic fall,
    output logic evt_nxt
);
    localparam int CW = $clog2(FILT_CNT + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   s, o_nxt;

    // Reset value of the chain makes s equal o at release, so no false edge.
    always_ff @(posedge clk) begin
        if (rst) sync <= {SYNC_STAGES{RST_BIT ^ INV_BIT}};
        else     sync <= {sync[SYNC_STAGES-2:0], d};
    end

    assign s = sync[SYNC_STAGES-1] ^ INV_BIT;

    always_comb begin
        o_nxt   = o;
        cnt_nxt = '0;
        if (byp) begin
            o_nxt = s;
        end else if (s != o) begin
            if (cnt == CW'(FILT_CNT - 1)) o_nxt = s;
            else                          cnt_nxt = cnt + CW'(1);
        end
    end

    assign evt_nxt = o ^ o_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            o    <= RST_BIT;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            o    <= o_nxt;
            cnt  <= cnt_nxt;
            rise <= ~o & o_nxt;
            fall <= o & ~o_nxt;
        end
    end
endmodule

module dbuf_filt_sync #(
    parameter int               WIDTH       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILT_CNT    = 4,
    parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] INV         = {WIDTH{1'b0}}
) (
    input  logic             CELCLK,
    input  logic             CELRST,
    input  logic             CELV,
    input  logic             CELG,
    input  logic             SUB,
    input  logic [WIDTH-1:0] i,
    input  logic             byp,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             chg
);
    logic [WIDTH-1:0] evt_nxt;
    logic             pwr_unused;

    // Supply pins exist only for netlist connectivity.
    assign pwr_unused = CELV ^ CELG ^ SUB;

    for (genvar n = 0; n < WIDTH; n++) begin : g_ch
        dbuf_filt_lane #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_CNT   (FILT_CNT),
            .RST_BIT    (RST_VAL[n]),
            .INV_BIT    (INV[n])
        ) u_lane (
            .clk    (CELCLK),
            .rst    (CELRST),
            .byp    (byp),
            .d      (i[n]),
            .o      (o[n]),
            .rise   (rise[n]),
            .fall   (fall[n]),
            .evt_nxt(evt_nxt[n])
        );
    end

    always_ff @(posedge CELCLK) begin
        if (CELRST) chg <= 1'b0;
        else        chg <= |evt_nxt;
    end
endmodule
